rv_fetch: RTL and testbench
===========================

# rv_fetch

Instruction fetch stage of the RV32 core. Owns the program counter, issues word-aligned reads on the instruction-memory request/grant/response bus, buffers returned words in a small in-order FIFO, and presents instruction + PC to the decode stage through a valid/ready handshake. Accepts a redirect (branch/jump/trap target) from downstream, which flushes buffered and in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
- FIFO_DEPTH, 2, instruction buffer entries; also the total credit (buffered + in-flight), power of two, ≥2

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- imem_req_o  output  1  read request valid
- imem_addr_o  output  32  read address, bits [1:0] always 0
- imem_gnt_i  input  1  request accepted this cycle (meaningful only when imem_req_o=1)
- imem_rvalid_i  input  1  read data valid; responses return in request order, earliest the cycle after grant
- imem_rdata_i  input  32  read data
- redirect_i  input  1  discard all younger instructions, restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new PC; bits [1:0] ignored (treated as 0)
- instr_o  output  32  instruction word to decode
- pc_o  output  32  address of instr_o
- valid_o  output  1  instr_o/pc_o valid
- ready_i  input  1  decode accepts this cycle

## Operation
- State: fetch_pc (next address to request), outstanding counter (0..FIFO_DEPTH), discard counter (0..FIFO_DEPTH), FIFO of {pc, instr}, count 0..FIFO_DEPTH.
- pop = valid_o & ready_i. push = imem_rvalid_i & (discard==0).
- Credit: imem_req_o = !redirect_i & (outstanding + count − pop < FIFO_DEPTH). Combinational path ready_i → imem_req_o is intended (sustains 1 instr/cycle with FIFO_DEPTH=2, 1-cycle memory).
- imem_addr_o = fetch_pc. On imem_req_o & imem_gnt_i: fetch_pc += 4 (wraps modulo 2^32, 32'hFFFF_FFFC → 0), outstanding +1.
- On imem_rvalid_i: outstanding −1. If discard>0: discard −1, word dropped. Else word pushed with its PC (PC tracked by a separate response-PC register advancing +4 per push, loaded on redirect).
- Grant and response in the same cycle: outstanding unchanged.
- valid_o = (count≠0) & !redirect_i; instr_o/pc_o = FIFO head. Outputs hold stable while valid_o & !ready_i.
- Redirect cycle: FIFO flushed (count→0), fetch_pc and response-PC ← {redirect_pc_i[31:2],2'b00}, discard ← outstanding − (imem_rvalid_i ? 1 : 0), outstanding updated normally, no request issued, no pop. A response arriving in the redirect cycle is dropped.
- Redirect while discard>0: discard ← same formula (all in-flight are stale).
- imem_rvalid_i with outstanding==0 is a protocol error; ignored, counters saturate at 0.

## Timing
- Reset values: imem_req_o 0 during reset, imem_addr_o = RESET_PC, instr_o 32'h0000_0013 (NOP), pc_o RESET_PC, valid_o 0; fetch_pc/response-PC = RESET_PC, counters 0.
- First request: cycle after rst_i deasserts (combinational from counters, so asserted in first clocked cycle).
- Latency: rvalid in cycle N → valid_o in N+1. Grant in N, 1-cycle memory → valid_o in N+2.
- Redirect in N → request to redirect target in N+1; first redirected instruction at valid_o in N+3 with 1-cycle memory.
- Throughput: 1 instr/cycle with continuous grant, 1-cycle memory, ready_i=1.
- Reset mid-operation: all state cleared immediately; in-flight responses after reset deassert are not tracked (memory is reset together with core).

## Test plan
- Reset release, 1-cycle memory always granting, ready_i=1 → imem_addr_o 0,4,8,…; valid_o from cycle 3 every cycle, pc_o 0,4,8 with matching instr_o.
- ready_i=0 for 5 cycles mid-stream → at most FIFO_DEPTH words buffered+in-flight, imem_req_o drops, no word lost or duplicated after ready_i returns.
- imem_gnt_i low for 3 cycles with req high → imem_addr_o held constant, fetch_pc not advanced.
- Two requests in flight, redirect_i with redirect_pc_i=32'h0000_0103 → both responses dropped, next request address 32'h0000_0100, next valid_o has pc_o 32'h100.
- Redirect in same cycle as a response and as valid_o&ready_i → valid_o low that cycle, response dropped, discard=outstanding−1, stream restarts at target.
- RESET_PC=32'hFFFF_FFF8, continuous fetch → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, pc_o follows.

Source files
------------

// File: rtl/rv_fetch.sv
// ---------------------------------------------------------------------------
// rv_fetch -- instruction fetch stage of the RV32 core.
//
// Owns the program counter, issues word-aligned reads on the instruction
// memory request/grant/response bus, buffers returned words in a small
// in-order FIFO and hands {instr, pc} to decode. A redirect from downstream
// flushes the FIFO and arranges for all in-flight responses to be dropped.
//
// Parameters:
//   RESET_PC    first PC fetched after reset (bits [1:0] must be 0)
//   FIFO_DEPTH  buffer entries and total credit (buffered + in-flight);
//               power of two, >= 2
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   imem_req_o            read request valid
//   imem_addr_o           read address (word aligned)
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i         read data valid (in request order, >= 1 cycle after grant)
//   imem_rdata_i          read data
//   redirect_i            discard younger instructions, restart at redirect_pc_i
//   redirect_pc_i         new PC (bits [1:0] ignored)
//   instr_o, pc_o         instruction word and its address for decode
//   valid_o, ready_i      decode handshake
//
// Handshakes: a transfer happens on a rising edge where the sender's valid
// (imem_req_o / valid_o) and the receiver's accept (imem_gnt_i / ready_i)
// are both high. While valid_o is high and ready_i low, instr_o/pc_o hold.
// imem_req_o may depend combinationally on ready_i so that a pop frees a
// credit in the same cycle (sustains 1 instr/cycle with a 1-cycle memory).
// ---------------------------------------------------------------------------
module rv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_rsp;
  logic          w_push;
  logic          w_req;
  logic          w_grant;
  logic [CW:0]   w_credit_used;
  logic [31:0]   w_redirect_pc;

  // Masking (rather than slicing) keeps every bit of redirect_pc_i in use.
  assign w_redirect_pc = redirect_pc_i & ~32'h0000_0003;

  assign w_valid = (r_count != '0) && !redirect_i;
  assign w_pop   = w_valid && ready_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp   = imem_rvalid_i && (r_outstanding != '0);
  // Stale responses (discard > 0) and anything arriving during a redirect
  // never reach the FIFO.
  assign w_push  = w_rsp && (r_discard == '0) && !redirect_i;

  // Credit counts the slot a same-cycle pop frees, hence the ready_i path.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count} - (CW+1)'(w_pop);
  assign w_req   = !rst_i && !redirect_i && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign w_grant = w_req && imem_gnt_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = w_valid;
  assign instr_o     = r_fifo_instr[r_rd_ptr];
  assign pc_o        = r_fifo_pc[r_rd_ptr];

  // Request side: fetch address and in-flight bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        // Everything still in flight after this cycle belongs to the old path.
        r_discard  <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_rsp && (r_discard != '0)) begin
          r_discard <= r_discard - 1'b1;
        end
      end
    end
  end

  // Response side: PC of the next kept response, FIFO pointers and count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_pc <= RESET_PC;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else if (redirect_i) begin
      r_resp_pc <= w_redirect_pc;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; entries reset to a NOP at RESET_PC so the outputs are
  // defined out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= NOP;
        r_fifo_pc[i]    <= RESET_PC;
      end
    end else if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
module tb_rv_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;

  // main DUT (RESET_PC 0, depth 2)
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  // wrap DUT (RESET_PC near top of memory, depth 4, always granted, always ready)
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;

  rv_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  rv_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .instr_o(w_instr), .pc_o(w_pc), .valid_o(w_valid), .ready_i(1'b1)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];    // {pc, instr}
  logic [63:0] exp_w_q[$];

  // Memory contents are a fixed function of the address, so a word fetched
  // from the wrong address shows up as an instr mismatch.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h02AB_CDEF, 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  // ---------------- memory model (main DUT) ----------------
  // Grants seen mid-cycle are queued with a due cycle; the head response is
  // presented from the next rising edge when due.
  int          cyc = 0;
  int          lat = 1;
  logic        nxt_v = 1'b0;
  logic [31:0] nxt_d = '0;
  logic [63:0] pend_q[$];   // {due, addr}

  always @(negedge clk) begin
    logic [63:0] head;
    if (rst_i) begin
      pend_q.delete();
      nxt_v = 1'b0;
    end else begin
      if (imem_req_o && imem_gnt_i) pend_q.push_back({32'(cyc + lat), imem_addr_o});
      nxt_v = 1'b0;
      if (pend_q.size() > 0) begin
        head = pend_q[0];
        if (head[63:32] <= 32'(cyc + 1)) begin
          nxt_v = 1'b1;
          nxt_d = mem_word(head[31:0]);
          void'(pend_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    imem_rvalid_i <= !rst_i && nxt_v;
    imem_rdata_i  <= nxt_d;
  end

  // ---------------- memory model (wrap DUT, 1-cycle, always grant) ----------------
  logic        w_nxt_v = 1'b0;
  logic [31:0] w_nxt_d = '0;

  always @(negedge clk) begin
    w_nxt_v = !rst_i && w_req;
    w_nxt_d = mem_word(w_addr);
  end

  always @(posedge clk) begin
    w_rvalid <= !rst_i && w_nxt_v;
    w_rdata  <= w_nxt_d;
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h, expected no transfer", pc_o, instr_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_o, e[63:32]);
        chk("sb_instr", instr_o, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_i && w_valid && exp_w_q.size() != 0) begin
      e = exp_w_q.pop_front();
      chk("wrap_pc", w_pc, e[63:32]);
      chk("wrap_instr", w_instr, e[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] wrap_addr_tbl [3];

  initial begin
    wrap_addr_tbl[0] = 32'hFFFF_FFF8;
    wrap_addr_tbl[1] = 32'hFFFF_FFFC;
    wrap_addr_tbl[2] = 32'h0000_0000;

    push_seq(32'h0000_0000, 64);
    exp_w_q.push_back({32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8)});
    exp_w_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    exp_w_q.push_back({32'h0000_0000, mem_word(32'h0000_0000)});
    exp_w_q.push_back({32'h0000_0004, mem_word(32'h0000_0004)});
    exp_w_q.push_back({32'h0000_0008, mem_word(32'h0000_0008)});

    // reset values
    step();
    step();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0000_0000);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0000_0000);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);

    rst_i = 1'b0;  // cycle 1 starts here

    // cycles 1..10: streaming at one instruction per cycle
    for (int k = 1; k <= 10; k++) begin
      ready_i = 1'b1;
      settle();
      chk("stream_req", 32'(imem_req_o), 32'd1);
      chk("stream_addr", imem_addr_o, 32'(4 * (k - 1)));
      if (k < 3) begin
        chk("stream_valid_early", 32'(valid_o), 32'd0);
      end else begin
        chk("stream_valid", 32'(valid_o), 32'd1);
        chk("stream_pc", pc_o, 32'(4 * (k - 3)));
      end
      if (k <= 3) chk("wrap_addr", w_addr, wrap_addr_tbl[k - 1]);
      step();
    end

    // cycles 11..15: decode stalls, credit exhausted, head held
    for (int k = 11; k <= 15; k++) begin
      ready_i = 1'b0;
      settle();
      chk("stall_req", 32'(imem_req_o), 32'd0);
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_pc", pc_o, 32'h0000_0020);
      step();
    end

    // cycles 16..19: resume
    for (int k = 16; k <= 19; k++) begin
      ready_i = 1'b1;
      settle();
      chk("resume_addr", imem_addr_o, 32'(40 + 4 * (k - 16)));
      step();
    end

    // cycles 20..22: grant withheld, address must not advance
    for (int k = 20; k <= 22; k++) begin
      imem_gnt_i = 1'b0;
      settle();
      chk("nogrant_req", 32'(imem_req_o), 32'd1);
      chk("nogrant_addr", imem_addr_o, 32'h0000_0038);
      step();
    end

    // cycles 23..26 stream, 27..34 stall to quiesce (FIFO full, nothing in flight)
    imem_gnt_i = 1'b1;
    for (int k = 23; k <= 26; k++) begin
      ready_i = 1'b1;
      step();
    end
    for (int k = 27; k <= 34; k++) begin
      ready_i = 1'b0;
      step();
    end

    // cycles 35,36: slow memory, drain FIFO while two requests go out
    lat = 3;
    for (int k = 35; k <= 36; k++) begin
      ready_i = 1'b1;
      settle();
      chk("inflight_req", 32'(imem_req_o), 32'd1);
      step();
    end

    // cycle 37: redirect with two requests in flight
    ready_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    lat           = 1;
    exp_q.delete();
    push_seq(32'h0000_0100, 16);
    settle();
    chk("redir1_req", 32'(imem_req_o), 32'd0);
    chk("redir1_valid", 32'(valid_o), 32'd0);
    step();

    // cycle 38: stale responses still owed, no credit yet
    redirect_i = 1'b0;
    ready_i    = 1'b1;
    settle();
    chk("redir1_addr", imem_addr_o, 32'h0000_0100);
    chk("redir1_req_blocked", 32'(imem_req_o), 32'd0);
    step();

    // cycle 39: first request of the new path
    settle();
    chk("redir1_req_new", 32'(imem_req_o), 32'd1);
    chk("redir1_addr_new", imem_addr_o, 32'h0000_0100);
    step();

    for (int k = 40; k <= 45; k++) step();

    // cycle 46: redirect coinciding with a response and a would-be pop
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    exp_q.delete();
    push_seq(32'h0000_0200, 8);
    settle();
    chk("redir2_rvalid_pre", 32'(imem_rvalid_i), 32'd1);
    chk("redir2_valid", 32'(valid_o), 32'd0);
    chk("redir2_req", 32'(imem_req_o), 32'd0);
    step();

    // cycle 47: request to target
    redirect_i = 1'b0;
    settle();
    chk("redir2_req_new", 32'(imem_req_o), 32'd1);
    chk("redir2_addr", imem_addr_o, 32'h0000_0200);
    chk("redir2_valid_n1", 32'(valid_o), 32'd0);
    step();

    // cycle 48
    settle();
    chk("redir2_valid_n2", 32'(valid_o), 32'd0);
    step();

    // cycle 49: first redirected instruction
    settle();
    chk("redir2_valid_n3", 32'(valid_o), 32'd1);
    chk("redir2_pc_n3", pc_o, 32'h0000_0200);
    step();

    for (int k = 50; k <= 56; k++) step();

    // stop consuming and let things settle
    ready_i = 1'b0;
    repeat (4) step();
    chk("drain_main", 32'(exp_q.size()), 32'd0);
    chk("drain_wrap", 32'(exp_w_q.size()), 32'd0);
    chk("prerst_pc", pc_o, 32'h0000_0220);

    // asynchronous reset mid-cycle
    rst_i = 1'b1;
    settle();
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_addr", imem_addr_o, 32'h0000_0000);
    chk("arst_pc", pc_o, 32'h0000_0000);
    chk("arst_instr", instr_o, 32'h0000_0013);
    chk("arst_w_addr", w_addr, 32'hFFFF_FFF8);
    step();
    step();
    rst_i = 1'b0;
    settle();
    chk("rerun_req", 32'(imem_req_o), 32'd1);
    chk("rerun_addr", imem_addr_o, 32'h0000_0000);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
